mci_arbiter: RTL and testbench

- Round-robin arbiter that shares one memory-controller-interface (MCI) port between NUM_REQ requesters, e.g. the instruction cache and the data cache.
- It sits between the caches and the main-memory model or controller.
- It serialises block transactions, holds exactly one transaction outstanding, and routes the response back to the granted requester.
- All request and response ports use mci_request_t / mci_response_t from memory_controller_interface.

---
 rtl/mci_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_mci_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mci_arbiter.sv
// Round-robin arbiter sharing one MCI memory port between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining MCI_ARB_TIMEOUT_EN.

package memory_controller_interface;
   localparam int MCI_ADDR_W = 32;
   localparam int MCI_DATA_W = 128;

   typedef struct packed {
      logic                  valid;
      logic                  rw;
      logic [MCI_ADDR_W-1:0] addr;
      logic [MCI_DATA_W-1:0] data;
   } mci_request_t;

   typedef struct packed {
      logic                  ready;
      logic [MCI_DATA_W-1:0] data;
   } mci_response_t;
endpackage

module mci_arbiter
   import memory_controller_interface::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  mci_request_t        i_req [NUM_REQ],
   output mci_response_t       o_res [NUM_REQ],
   output mci_request_t        o_mem_req,
   input  mci_response_t       i_mem_res,
   output logic [NUM_REQ-1:0]  o_grant,
   output logic                o_timeout
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("mci_arbiter: NUM_REQ must be 2..8, TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic                   hold_rw_q, hold_rw_d;
   logic [MCI_ADDR_W-1:0]  hold_addr_q, hold_addr_d;
   logic [MCI_DATA_W-1:0]  hold_data_q, hold_data_d;
   logic [MCI_DATA_W-1:0]  rdata_q, rdata_d;

   logic                   pick_vld;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W-1:0]       cand;
   logic                   to_hit;

   // Lowest offset from last_q wins; the loop runs far-to-near so the
   // nearest valid candidate is the last one written.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = last_q;
      cand     = last_q;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
         if (i_req[cand].valid) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

`ifdef MCI_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d;

   assign to_hit = (state_q == S_WAIT) && !i_mem_res.ready &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      to_d  = to_hit;
      if (state_q == S_ISSUE) begin
         cnt_d = '0;
      end else if (state_q == S_WAIT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge i_clk) begin
      if (!i_rst && to_hit) begin
         $display("[MCIARB] timeout req %0d addr [%x]",
                  last_q, hold_addr_q);
      end
   end
`endif
`else
   logic to_q;

   assign to_hit = 1'b0;
   assign to_q   = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (pick_vld) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (i_mem_res.ready || to_hit) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Holding register, grant, pointer and captured read data
   always_comb begin
      grant_d     = grant_q;
      last_d      = last_q;
      hold_rw_d   = hold_rw_q;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;
      rdata_d     = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               grant_d     = NUM_REQ'(1) << pick_idx;
               last_d      = pick_idx;
               hold_rw_d   = i_req[pick_idx].rw;
               hold_addr_d = i_req[pick_idx].addr;
               hold_data_d = i_req[pick_idx].data;
            end
         end
         S_WAIT: begin
            if (i_mem_res.ready) begin
               rdata_d = i_mem_res.data;
            end else if (to_hit) begin
               rdata_d = '0;
            end
         end
         S_RESP:  grant_d = '0;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         grant_q     <= '0;
         last_q      <= IDX_W'(NUM_REQ - 1);
         hold_rw_q   <= 1'b0;
         hold_addr_q <= '0;
         hold_data_q <= '0;
         rdata_q     <= '0;
      end else begin
         grant_q     <= grant_d;
         last_q      <= last_d;
         hold_rw_q   <= hold_rw_d;
         hold_addr_q <= hold_addr_d;
         hold_data_q <= hold_data_d;
         rdata_q     <= rdata_d;
      end
   end

   // Outputs; address stays on the bus through WAIT for combinational reads
   always_comb begin
      o_mem_req = '0;
      o_timeout = 1'b0;
      for (int n = 0; n < NUM_REQ; n++) begin
         o_res[n] = '0;
      end
      unique case (state_q)
         S_ISSUE: begin
            o_mem_req.valid = 1'b1;
            o_mem_req.rw    = hold_rw_q;
            o_mem_req.addr  = hold_addr_q;
            o_mem_req.data  = hold_data_q;
         end
         S_WAIT: begin
            o_mem_req.rw   = hold_rw_q;
            o_mem_req.addr = hold_addr_q;
            o_mem_req.data = hold_data_q;
         end
         S_RESP: begin
            o_res[last_q].ready = 1'b1;
            o_res[last_q].data  = rdata_q;
            o_timeout           = to_q;
         end
         default: ;
      endcase
   end

   assign o_grant = grant_q;

endmodule

// File: tb/tb_mci_arbiter.sv
// Scoreboard bench for mci_arbiter: requester drivers, a memory model
// with programmable latency, and a response monitor.

module tb_mci_arbiter;
   import memory_controller_interface::*;

   localparam int N  = 2;
   localparam int TO = 8;
   localparam logic [MCI_DATA_W-1:0] WD =
      128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

   typedef struct {
      int                    idx;
      bit                    chk;
      logic [MCI_DATA_W-1:0] data;
      bit                    to;
   } exp_t;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   mci_request_t  i_req [N] = '{default: '0};
   mci_response_t o_res [N];
   mci_request_t  o_mem_req;
   mci_response_t i_mem_res = '0;
   logic [N-1:0]  o_grant;
   logic          o_timeout;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   exp_t         sb [$];
   mci_request_t rq [N][$];
   bit           done [N];
   bit           flush [N];
   int           req_cyc [N];
   int           res_n [N];
   int           grant_log [$];

   logic [MCI_DATA_W-1:0] mem [logic [MCI_ADDR_W-1:0]];
   logic [MCI_DATA_W-1:0] ref_mem [logic [MCI_ADDR_W-1:0]];

   int lat = 1;
   int mcnt = 0;
   bit late_pulse = 0;
   int mv_cnt = 0, mv_cyc = 0, mr_cyc = 0;
   int res_cyc = 0, res_total = 0;
   logic [MCI_DATA_W-1:0] res_data = '0;
   bit outstanding = 0, prev_valid = 0;

   mci_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_req     (i_req),
      .o_res     (o_res),
      .o_mem_req (o_mem_req),
      .i_mem_res (i_mem_res),
      .o_grant   (o_grant),
      .o_timeout (o_timeout)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc++;

   function automatic logic [MCI_DATA_W-1:0] pat(input logic [31:0] a);
      return {a, ~a, a ^ 32'h5A5A_0F0F, 32'hC0DE_0000 | a};
   endfunction

   function automatic logic [MCI_DATA_W-1:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return pat(a);
   endfunction

   function automatic logic [MCI_DATA_W-1:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return pat(a);
   endfunction

   // Requesters: hold valid until the ready pulse, then take the next item
   always begin
      @(posedge i_clk);
      #1;
      for (int n = 0; n < N; n++) begin
         if (flush[n]) begin
            i_req[n].valid = 1'b0;
            rq[n].delete();
            flush[n] = 0;
         end
         if (done[n]) begin
            i_req[n].valid = 1'b0;
            done[n] = 0;
         end
         if (!i_req[n].valid && rq[n].size() > 0) begin
            i_req[n] = rq[n].pop_front();
            i_req[n].valid = 1'b1;
            req_cyc[n] = cyc;
         end
      end
   end

   // Memory: ready pulses lat cycles after valid (lat=0 never answers)
   always begin
      @(posedge i_clk);
      #1;
      i_mem_res.ready = 1'b0;
      if (o_mem_req.valid) begin
         if (o_mem_req.rw) mem[o_mem_req.addr] = o_mem_req.data;
         mcnt = lat;
      end else if (mcnt > 0) begin
         mcnt--;
         if (mcnt == 0) i_mem_res.ready = 1'b1;
      end
      if (late_pulse) begin
         i_mem_res.ready = 1'b1;
         late_pulse = 0;
      end
      i_mem_res.data = mem_rd(o_mem_req.addr);
   end

   always @(negedge i_clk) begin : mon
      int nrdy;
      int idx;
      bit bad;
      exp_t e;
      logic [N-1:0] g;
      if (o_timeout) outstanding = 0;
      if (o_mem_req.valid) begin
         mv_cnt++;
         mv_cyc = cyc;
         vectors++;
         if (outstanding || prev_valid) begin
            miscompares++;
            $display("FAIL mem_overlap: valid at cycle %0d outstanding=%0b prev=%0b, need 0/0",
                     cyc, outstanding, prev_valid);
         end
         outstanding = 1;
      end else if (i_mem_res.ready && outstanding) begin
         mr_cyc = cyc;
         outstanding = 0;
      end
      prev_valid = o_mem_req.valid;
      nrdy = 0;
      idx = 0;
      for (int n = 0; n < N; n++) begin
         if (o_res[n].ready) begin
            nrdy++;
            idx = n;
         end
      end
      if (nrdy > 1 || (o_timeout && nrdy == 0)) begin
         vectors++;
         miscompares++;
         $display("FAIL res_pulse: %0d ready pulses timeout=%0b at cycle %0d, need at most 1 with timeout",
                  nrdy, o_timeout, cyc);
      end else if (nrdy == 1) begin
         res_cyc = cyc;
         res_total++;
         res_n[idx]++;
         res_data = o_res[idx].data;
         done[idx] = 1;
         grant_log.push_back(idx);
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_res: req %0d pulsed ready at cycle %0d, need no pulse",
                     idx, cyc);
         end else begin
            e = sb.pop_front();
            g = '0;
            g[idx] = 1'b1;
            bad = (idx != e.idx) || (o_grant !== g) || (o_timeout !== e.to);
            if (e.chk && o_res[idx].data !== e.data) bad = 1;
            for (int m = 0; m < N; m++) begin
               if (m != idx && o_res[m] !== '0) bad = 1;
            end
            if (bad) begin
               miscompares++;
               $display("FAIL response: req %0d data %h grant %b to %0b, need req %0d data %h to %0b",
                        idx, o_res[idx].data, o_grant, o_timeout, e.idx, e.data, e.to);
            end
         end
      end
   end

   task automatic send(input int n, input bit rw, input logic [31:0] a,
                       input logic [MCI_DATA_W-1:0] d, input bit to);
      exp_t e;
      mci_request_t r;
      r = '0;
      r.rw = rw;
      r.addr = a;
      r.data = d;
      e.idx = n;
      e.to = to;
      e.chk = to || !rw;
      e.data = to ? '0 : (rw ? d : ref_rd(a));
      if (rw) ref_mem[a] = d;
      sb.push_back(e);
      rq[n].push_back(r);
   endtask

   task automatic wait_resp(input int target, input int budget, input string what);
      int k = 0;
      while (res_total < target && k < budget) begin
         @(negedge i_clk);
         k++;
      end
      vectors++;
      if (res_total < target) begin
         miscompares++;
         $display("FAIL %s_wait: got %0d responses, need %0d", what, res_total, target);
      end
   endtask

   task automatic wait_mv(input int target, input string what);
      int k = 0;
      while (mv_cnt < target && k < 30) begin
         @(negedge i_clk);
         k++;
      end
      vectors++;
      if (mv_cnt < target) begin
         miscompares++;
         $display("FAIL %s_mv_wait: got %0d mem valids, need %0d", what, mv_cnt, target);
      end
   endtask

   task automatic apply_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      vectors++;
      if (o_grant !== '0) begin
         miscompares++;
         $display("FAIL rst_grant: %b, need 0", o_grant);
      end
      vectors++;
      if (o_mem_req !== '0) begin
         miscompares++;
         $display("FAIL rst_mem_req: %h, need 0", o_mem_req);
      end
      vectors++;
      if (o_timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_timeout: %b, need 0", o_timeout);
      end
      vectors++;
      if (o_res[0] !== '0 || o_res[1] !== '0) begin
         miscompares++;
         $display("FAIL rst_res: %h %h, need 0", o_res[0], o_res[1]);
      end
   endtask

   task automatic test_single();
      int m0 = mv_cnt;
      int r0 = res_total;
      lat = 5;
      send(0, 1'b0, 32'h40, '0, 1'b0);
      wait_resp(r0 + 1, 60, "single");
      repeat (3) @(negedge i_clk);
      vectors++;
      if (mv_cnt - m0 != 1) begin
         miscompares++;
         $display("FAIL single_mv_count: %0d valid cycles, need 1", mv_cnt - m0);
      end
      vectors++;
      if (mv_cyc - req_cyc[0] != 1) begin
         miscompares++;
         $display("FAIL single_issue_lat: %0d, need 1", mv_cyc - req_cyc[0]);
      end
      vectors++;
      if (mr_cyc - mv_cyc != 5) begin
         miscompares++;
         $display("FAIL single_mem_lat: %0d, need 5", mr_cyc - mv_cyc);
      end
      vectors++;
      if (res_cyc - mr_cyc != 1) begin
         miscompares++;
         $display("FAIL single_resp_lat: %0d, need 1", res_cyc - mr_cyc);
      end
      vectors++;
      if (res_data !== pat(32'h40)) begin
         miscompares++;
         $display("FAIL single_data: %h, need %h", res_data, pat(32'h40));
      end
   endtask

   task automatic test_round_robin();
      int order [4] = '{0, 1, 0, 1};
      int g0;
      int r0;
      apply_reset();
      g0 = grant_log.size();
      r0 = res_total;
      lat = 2;
      send(0, 1'b0, 32'h200, '0, 1'b0);
      send(1, 1'b0, 32'h300, '0, 1'b0);
      send(0, 1'b0, 32'h240, '0, 1'b0);
      send(1, 1'b0, 32'h340, '0, 1'b0);
      wait_resp(r0 + 4, 200, "rr");
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (grant_log.size() <= g0 + i) begin
            miscompares++;
            $display("FAIL rr_order[%0d]: missing, need %0d", i, order[i]);
         end else if (grant_log[g0 + i] != order[i]) begin
            miscompares++;
            $display("FAIL rr_order[%0d]: %0d, need %0d", i, grant_log[g0 + i], order[i]);
         end
      end
   endtask

   task automatic test_write_read();
      int r0 = res_total;
      int n1;
      lat = 1;
      send(1, 1'b1, 32'h80, WD, 1'b0);
      wait_resp(r0 + 1, 40, "wr");
      n1 = res_n[1];
      send(0, 1'b0, 32'h80, '0, 1'b0);
      wait_resp(r0 + 2, 40, "rd");
      vectors++;
      if (res_n[1] != n1) begin
         miscompares++;
         $display("FAIL wr_rd_stray: req1 pulsed %0d times, need 0", res_n[1] - n1);
      end
      vectors++;
      if (res_data !== WD) begin
         miscompares++;
         $display("FAIL wr_rd_data: %h, need %h", res_data, WD);
      end
   endtask

   task automatic test_reset_wait();
      int m0 = mv_cnt;
      int r0;
      mci_request_t r;
      lat = 0;
      r = '0;
      r.addr = 32'h100;
      rq[0].push_back(r);
      wait_mv(m0 + 1, "rstw");
      repeat (2) @(negedge i_clk);
      i_rst = 1'b1;
      flush[0] = 1;
      outstanding = 0;
      @(negedge i_clk);
      i_rst = 1'b0;
      r0 = res_total;
      vectors++;
      if (o_grant !== '0 || o_mem_req !== '0) begin
         miscompares++;
         $display("FAIL rstw_idle: grant %b mem_req %h, need 0", o_grant, o_mem_req);
      end
      late_pulse = 1;
      repeat (4) @(negedge i_clk);
      vectors++;
      if (res_total != r0 || o_grant !== '0) begin
         miscompares++;
         $display("FAIL rstw_late_ready: %0d responses grant %b, need 0 and 0",
                  res_total - r0, o_grant);
      end
      lat = 1;
      send(1, 1'b0, 32'h140, '0, 1'b0);
      wait_resp(r0 + 1, 40, "rstw");
      vectors++;
      if (mv_cyc - req_cyc[1] != 1) begin
         miscompares++;
         $display("FAIL rstw_reissue_lat: %0d, need 1", mv_cyc - req_cyc[1]);
      end
   endtask

`ifdef MCI_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int r0;
      int m0;
      int tmv;
      apply_reset();
      r0 = res_total;
      m0 = mv_cnt;
      lat = 0;
      send(0, 1'b0, 32'h500, '0, 1'b1);
      send(1, 1'b0, 32'h540, '0, 1'b0);
      wait_mv(m0 + 1, "to");
      tmv = mv_cyc;
      lat = 2;
      wait_resp(r0 + 1, 40, "to");
      vectors++;
      if (res_cyc - (tmv + 1) != TO) begin
         miscompares++;
         $display("FAIL to_delay: %0d cycles after WAIT entry, need %0d",
                  res_cyc - (tmv + 1), TO);
      end
      wait_resp(r0 + 2, 40, "to_next");
      vectors++;
      if (grant_log[$] != 1) begin
         miscompares++;
         $display("FAIL to_next_grant: %0d, need 1", grant_log[$]);
      end
   endtask
`endif

   initial begin
      for (int n = 0; n < N; n++) begin
         done[n] = 0;
         flush[n] = 0;
         req_cyc[n] = 0;
         res_n[n] = 0;
      end
      test_reset();
      test_single();
      test_round_robin();
      test_write_read();
      test_reset_wait();
`ifdef MCI_ARB_TIMEOUT_EN
      test_timeout();
`endif
      repeat (3) @(negedge i_clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain: %0d expected responses left, need 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
